// File: rtl/run_ctrl_if.sv
// run_ctrl_if: debugger/core-facing signal bundle between the board top level and run_ctrl
interface run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       clkMode;
    logic             start;
    logic             done;
    logic [15:0]      pc;
    logic             bpEnable;
    logic [15:0]      bpAddr;
    logic             cpuClk;
    logic             cpuRise;
    logic             enable;
    logic [CNT_W-1:0] cycleCount;
    logic [1:0]       haltCause;
    modport master (
        output clkMode, start, done, pc, bpEnable, bpAddr,
        input  cpuClk, cpuRise, enable, cycleCount, haltCause
    );
    modport slave (
        input  clkMode, start, done, pc, bpEnable, bpAddr,
        output cpuClk, cpuRise, enable, cycleCount, haltCause
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run-control FSM and glitch-free gated CPU clock for the mu0 core
module run_ctrl #(
    parameter int SLOW_DIV = 6318000,
    parameter int CNT_W    = 32
) (
    input logic       clk,
    input logic       reset,
    run_ctrl_if.slave bus
);
    localparam int DW = $clog2(SLOW_DIV + 1);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [1:0] cause_n;
    logic phase, phase_n, start_seen, since_resume, req, bp_hit, div_end;
    logic en_n, clk_n, clr_cnt, resume;
    always_comb begin
        req = bus.start != start_seen;
        bp_hit = bus.bpEnable && bus.pc == bus.bpAddr && since_resume;
        div_end = div_cnt == DW'(SLOW_DIV - 1);
        div_n = bus.clkMode == 4'd2 && !div_end ? div_cnt + 1'b1 : '0;
        phase_n = bus.clkMode == 4'd1 ? ~phase :
                  bus.clkMode == 4'd2 ? phase ^ div_end :
                  bus.clkMode == 4'd4;
        state_n = state;
        cause_n = bus.haltCause;
        clr_cnt = 1'b0;
        resume = 1'b0;
        case (state)
            IDLE: if (req) begin
                state_n = RUN;
                cause_n = 2'd0;
                clr_cnt = 1'b1;
                resume = 1'b1;
            end
            RUN: if (bus.done) begin
                state_n = HALT;
                cause_n = 2'd1;
            end else if (bp_hit) begin
                state_n = HALT;
                cause_n = 2'd2;
            end else if (req) begin
                state_n = HALT;
                cause_n = 2'd3;
            end
            HALT: if (req) begin
                state_n = RUN;
                cause_n = 2'd0;
                resume = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        en_n = state_n == RUN;
        // both gate terms come from registers, so cpuClk never produces a runt pulse
        clk_n = phase_n & en_n;
    end
    always_ff @(posedge clk) begin
        start_seen <= bus.start;
        if (reset) begin
            state <= IDLE;
            phase <= 1'b0;
            div_cnt <= '0;
            since_resume <= 1'b0;
            bus.enable <= 1'b0;
            bus.cpuClk <= 1'b0;
            bus.cpuRise <= 1'b0;
            bus.cycleCount <= '0;
            bus.haltCause <= 2'd0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            div_cnt <= div_n;
            since_resume <= resume ? 1'b0 : since_resume | bus.cpuRise;
            bus.enable <= en_n;
            bus.cpuClk <= clk_n;
            bus.cpuRise <= clk_n & ~bus.cpuClk;
            bus.cycleCount <= clr_cnt ? '0 : bus.cycleCount + CNT_W'(bus.cpuRise);
            bus.haltCause <= cause_n;
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed vectors for run_ctrl, checked through a timed expectation scoreboard
module tb_run_ctrl;
    typedef struct {
        bit [127:0] tag;
        int         at;
        bit         en;
        bit         ck;
        bit [1:0]   hc;
        bit [31:0]  cc;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int cyc = 0;
    int vectors = 0;
    int fails = 0;
    bit step_pc = 1'b0;
    exp_t exp_q[$];
    run_ctrl_if #(.CNT_W(32)) bus();
    run_ctrl #(.SLOW_DIV(3), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (bus.enable !== e.en || bus.cpuClk !== e.ck || bus.haltCause !== e.hc || bus.cycleCount !== e.cc) begin
                fails++;
                $display("FAIL %0s @cyc %0d: got en=%0b ck=%0b hc=%0d cc=%0d, want en=%0b ck=%0b hc=%0d cc=%0d",
                         e.tag, cyc, bus.enable, bus.cpuClk, bus.haltCause, bus.cycleCount, e.en, e.ck, e.hc, e.cc);
            end
        end
    end
    task automatic tick(input bit [127:0] tag, input bit en, input bit ck, input bit [1:0] hc, input int cc);
        exp_q.push_back('{tag, cyc + 1, en, ck, hc, 32'(cc)});
        @(negedge clk);
        if (step_pc && bus.cpuRise === 1'b1) bus.pc = bus.pc + 16'd1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
    initial begin
        int ecc;
        bit prev, e;
        reset = 1'b1;
        bus.clkMode = 4'd0;
        bus.start = 1'b0;
        bus.done = 1'b0;
        bus.pc = 16'd0;
        bus.bpEnable = 1'b0;
        bus.bpAddr = 16'd0;
        @(negedge clk);
        repeat (3) tick("reset", 0, 0, 0, 0);
        reset = 1'b0;
        bus.clkMode = 4'd1;
        bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) tick("fast", 1, 1'(k % 2), 0, k / 2);
        bus.done = 1'b1;
        tick("done", 0, 0, 1, 10);
        bus.done = 1'b0;
        repeat (3) tick("done_frozen", 0, 0, 1, 10);
        bus.bpEnable = 1'b1;
        bus.bpAddr = 16'h0005;
        bus.pc = 16'd0;
        step_pc = 1'b1;
        bus.start = ~bus.start;
        for (int k = 25; k <= 33; k++) tick("bp_run", 1, 1'(k % 2), 0, 10 + (k - 24) / 2);
        repeat (2) tick("bp_halt", 0, 0, 2, 15);
        bus.start = ~bus.start;
        for (int k = 36; k <= 40; k++) tick("bp_resume", 1, 1'(k % 2), 0, 15 + (k - 36) / 2);
        step_pc = 1'b0;
        bus.bpEnable = 1'b0;
        bus.start = ~bus.start;
        repeat (2) tick("abort", 0, 0, 3, 17);
        bus.start = ~bus.start;
        tick("resume2", 1, 1, 0, 17);
        tick("resume2", 1, 0, 0, 18);
        bus.start = ~bus.start;
        bus.done = 1'b1;
        tick("start_done", 0, 0, 1, 18);
        bus.done = 1'b0;
        repeat (2) tick("no_restart", 0, 0, 1, 18);
        bus.clkMode = 4'd2;
        bus.start = ~bus.start;
        tick("slow_entry", 1, 1, 0, 18);
        tick("slow_entry", 1, 1, 0, 19);
        ecc = 19;
        prev = 1'b0;
        for (int k = 50; k <= 73; k++) begin
            e = ((k - 50) % 6) >= 3;
            tick("slow", 1, e, 0, ecc);
            if (e && !prev) ecc++;
            prev = e;
        end
        bus.start = ~bus.start;
        tick("slow_abort", 0, 0, 3, 23);
        bus.clkMode = 4'd3;
        bus.start = ~bus.start;
        tick("man_entry", 1, 0, 0, 23);
        ecc = 23;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.clkMode = ((i / 2) % 2 == 0) ? 4'd4 : 4'd3;
            e = bus.clkMode == 4'd4;
            tick("manual", 1, e, 0, ecc);
            if (e && !prev) ecc++;
            prev = e;
        end
        tick("manual_end", 1, 0, 0, 26);
        bus.clkMode = 4'd1;
        reset = 1'b1;
        bus.start = ~bus.start;
        tick("rst_mid", 0, 0, 0, 0);
        reset = 1'b0;
        repeat (4) tick("rst_idle", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL pending: %0d expectations never checked, want 0", exp_q.size());
            fails += exp_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control and CPU clock generator for the MU0 board top level. It sits directly upstream of the mu0 core. It turns the UART debugger's clock-mode selection and start toggle into a glitch-free gated CPU clock and an enable level. It also stops the core on `done`, on a PC breakpoint, or on a second start request, and counts executed CPU clock edges.

## Interface
Parameters:
- `SLOW_DIV`, default 6318000: system-clock cycles per half-period of the slow CPU clock; legal range ≥ 1.
- `CNT_W`, default 32: width of `cycleCount`.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `clkMode`  in  4  clock mode: 0 OFF, 1 FAST, 2 SLOW, 3 MANUAL_OFF, 4 MANUAL_ON; codes 5–15 behave as OFF.
- `start`  in  1  toggle-style request from the UART block; every change of level is one request.
- `done`  in  1  level from mu0; high means the program has halted.
- `pc`  in  16  current mu0 program counter.
- `bpEnable`  in  1  breakpoint armed.
- `bpAddr`  in  16  breakpoint address.
- `cpuClk`  out  1  registered gated CPU clock.
- `cpuRise`  out  1  one-cycle pulse that is high in the cycle in which `cpuClk` goes from 0 to 1.
- `enable`  out  1  high while in RUN.
- `cycleCount`  out  CNT_W  number of `cpuRise` pulses since the last start from IDLE.
- `haltCause`  out  2  0 none, 1 done, 2 breakpoint, 3 abort.

## Operation
- Phase generator (free-running, independent of run state); `phase` register:
  - FAST: toggles every `clk`.
  - SLOW: `divCnt` counts 0..SLOW_DIV-1. At SLOW_DIV-1, `divCnt` returns to 0 and `phase` toggles.
  - MANUAL_ON: `phase` = 1. MANUAL_OFF / OFF / other codes: `phase` = 0.
  - `divCnt` is forced to 0 in every cycle in which the mode is not SLOW.
- Start detection: `startSeen` register. A request exists when `start != startSeen`. The request is consumed (`startSeen <= start`) in the same cycle in every state.
- FSM states are IDLE, RUN and HALT.
  - IDLE → RUN on a request. `cycleCount` clears to 0 and `haltCause` to 0.
  - RUN → HALT on the first cause found, in this priority order:
    1. `done`=1 → `haltCause` = 1.
    2. Breakpoint: `bpEnable` && `pc == bpAddr` && `sinceResume` = 1 → `haltCause` = 2.
    3. Request (abort) → `haltCause` = 3.
  - A request that coincides with a higher-priority cause is consumed and discarded.
  - HALT → RUN on a request. `haltCause` clears to 0 and `cycleCount` is kept (resume).
    - If `done` is still high at that point, the FSM re-enters HALT with cause 1 on the next cycle.
  - `sinceResume` clears on every entry to RUN and sets on the first `cpuRise`. This lets the core step off the address that caused the breakpoint.
- `enable` = (state == RUN), registered.
- `cpuClk` is registered as `phaseNext & enableNext`, so it drops in the same cycle that `enable` drops. No partial pulses are produced, because both terms come from registers.
- `cycleCount` increments on `cpuRise` and wraps modulo 2^CNT_W.

## Timing
- Reset values (all set when `reset`=1 on a `clk` edge):
  - State = IDLE; `phase`, `divCnt`, `cpuClk`, `cpuRise`, `enable`, `cycleCount`, `haltCause`, `sinceResume` = 0.
  - `startSeen` <= `start`, so a level present at reset is not a request.
- Reset has priority over every other event, including a request in the same cycle.
- Request → `enable`=1: 1 `clk`. `cpuClk` can first rise in that same cycle if `phaseNext` = 1.
- `done` sampled high → `enable` = 0 and `cpuClk` = 0 on the next edge (1-cycle latency). At most one further `cpuClk` rise can occur after the core raised `done`.
- The breakpoint compare uses `pc` as sampled on the edge. The halt takes effect 1 `clk` later, with the same latency as `done`.
- FAST mode: the `cpuClk` period is 2 `clk`. SLOW mode: the period is 2·SLOW_DIV `clk`.
- Mode change mid-run: the new mode applies on the next edge, and `divCnt` restarts from 0.

## Test plan
- Reset, then FAST mode, then toggle `start`:
  - `enable`=1 after 1 cycle.
  - `cpuClk` toggles every cycle.
  - After 10 `cpuRise` pulses, `cycleCount` = 10.
  - `haltCause` = 0.
- SLOW mode with SLOW_DIV=3, running: `cpuClk` high for 3 cycles and low for 3 cycles. Checked across 4 periods.
- Running in FAST, `done` asserted for 1 cycle:
  - Next cycle: `enable`=0, `cpuClk`=0, `haltCause`=1.
  - `cycleCount` stays frozen.
- Breakpoint:
  - Setup: `bpEnable`=1, `bpAddr`=0x0005; `pc` steps 0..5 on each `cpuRise`.
  - Response: the FSM halts with `haltCause`=2 one cycle after `pc`=5.
  - Toggle `start`: RUN resumes with no immediate re-halt, and `cycleCount` continues from its value.
- Toggle `start` while running → `haltCause`=3.
- Toggle `start` and assert `done` in the same cycle → `haltCause`=1, and the toggle is consumed (no restart).
- MANUAL_ON/MANUAL_OFF alternated while running → exactly one `cpuRise` per OFF→ON change.
- Reset asserted mid-RUN with `start` toggling in the same cycle:
  - All outputs return to 0 and the state is IDLE.
  - No spurious request appears afterwards.
